btn_menu_ctrl: RTL

- Front-end controller that turns the raw CTRLbtn/UPbtn/DOWNbtn pushbuttons into clean, arbitrated command events.
- Sequences a small menu state machine: navigate between items, edit the selected item's value, commit.
- Sits between the board buttons and the display/task datapath, which consumes its selection, mode and value outputs.
- Only one command is accepted per lockout window, so downstream logic never sees bounce or overlapping commands.

---
 rtl/btn_menu_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/btn_menu_ctrl.sv
// btn_menu_ctrl: pushbutton front end and menu sequencer.
// Raw CTRL/UP/DOWN buttons are synchronised and debounced, then turned into
// press events. The events are arbitrated and rate-limited by a lockout
// window, and finally drive a two-state NAV/EDIT menu over a small array of
// 4-bit item values.

module btn_menu_ctrl #(
    parameter int DEBOUNCE_CYC = 2000000,
    parameter int LOCKOUT_CYC  = 10000000,
    parameter int NUM_ITEMS    = 4,
    parameter int IDX_W        = 2,
    parameter int VAL_MAX      = 15
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             CTRLbtn,
    input  logic             UPbtn,
    input  logic             DOWNbtn,
    output logic [IDX_W-1:0] sel_idx,
    output logic             edit_mode,
    output logic [3:0]       sel_val,
    output logic             evt_ctrl,
    output logic             evt_up,
    output logic             evt_down,
    output logic             commit
);

    // Counter widths are at least one bit so that degenerate parameter
    // values (1 cycle) still elaborate.
    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int LK_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [LK_W-1:0]  LK_LOAD  = LK_W'(LOCKOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ITEMS - 1);
    localparam logic [3:0]       VAL_TOP  = 4'(VAL_MAX);

    // Bit positions of the three buttons inside the packed button vectors.
    localparam int B_CTRL = 2;
    localparam int B_UP   = 1;
    localparam int B_DOWN = 0;

    typedef enum logic {
        NAV  = 1'b0,
        EDIT = 1'b1
    } state_t;

    logic [2:0]       w_btn_raw;
    logic [2:0]       r_sync_1;
    logic [2:0]       r_sync_2;
    logic [2:0]       r_deb;
    logic [2:0]       r_deb_d;
    logic [DB_W-1:0]  r_db_cnt [3];
    logic [2:0]       w_press;

    logic [LK_W-1:0]  r_lock_cnt;
    logic             w_lock_idle;
    logic             w_acc_ctrl;
    logic             w_acc_up;
    logic             w_acc_down;
    logic             w_acc_any;

    logic             r_evt_ctrl;
    logic             r_evt_up;
    logic             r_evt_down;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_edit_mode;
    logic             w_commit_next;
    logic             r_commit;

    logic [IDX_W-1:0] r_sel_idx;
    logic [3:0]       r_val [NUM_ITEMS];
    logic [3:0]       w_cur_val;

    assign w_btn_raw = {CTRLbtn, UPbtn, DOWNbtn};

    // Two-flop synchronisers bring the asynchronous buttons into CLK.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_sync_1 <= '0;
            r_sync_2 <= '0;
        end else begin
            r_sync_1 <= w_btn_raw;
            r_sync_2 <= r_sync_1;
        end
    end

    // Per-button debounce: count cycles of disagreement, flip after a full stable run.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_deb <= '0;
            for (int b = 0; b < 3; b++) begin
                r_db_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 3; b++) begin
                if (r_sync_2[b] == r_deb[b]) begin
                    r_db_cnt[b] <= '0;
                end else if (r_db_cnt[b] == DB_LAST) begin
                    r_deb[b]    <= ~r_deb[b];
                    r_db_cnt[b] <= '0;
                end else begin
                    r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
                end
            end
        end
    end

    // Delayed copy of the debounced levels for rising-edge detection.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_deb_d <= '0;
        end else begin
            r_deb_d <= r_deb;
        end
    end

    // A press is a debounced rising edge; releases never produce an event.
    assign w_press     = r_deb & ~r_deb_d;
    assign w_lock_idle = (r_lock_cnt == '0);

    // Fixed-priority arbitration CTRL > UP > DOWN, gated by the lockout window.
    always_comb begin
        w_acc_ctrl = 1'b0;
        w_acc_up   = 1'b0;
        w_acc_down = 1'b0;
        if (w_lock_idle) begin
            if (w_press[B_CTRL]) begin
                w_acc_ctrl = 1'b1;
            end else if (w_press[B_UP]) begin
                w_acc_up = 1'b1;
            end else if (w_press[B_DOWN]) begin
                w_acc_down = 1'b1;
            end
        end
        w_acc_any = w_acc_ctrl | w_acc_up | w_acc_down;
    end

    // Lockout counter: reloaded by every accepted event, then runs down to zero.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_lock_cnt <= '0;
        end else if (w_acc_any) begin
            r_lock_cnt <= LK_LOAD;
        end else if (!w_lock_idle) begin
            r_lock_cnt <= r_lock_cnt - 1'b1;
        end
    end

    // Register the accepted event as a single-cycle pulse.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_evt_ctrl <= 1'b0;
            r_evt_up   <= 1'b0;
            r_evt_down <= 1'b0;
        end else begin
            r_evt_ctrl <= w_acc_ctrl;
            r_evt_up   <= w_acc_up;
            r_evt_down <= w_acc_down;
        end
    end

    // Menu state register.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= NAV;
        end else begin
            r_state <= w_state_next;
        end
    end

    // CTRL toggles between navigating and editing; UP/DOWN never change state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            NAV:     if (r_evt_ctrl) w_state_next = EDIT;
            EDIT:    if (r_evt_ctrl) w_state_next = NAV;
            default: w_state_next = NAV;
        endcase
    end

    // Mode flag follows the state; leaving EDIT via CTRL requests a commit pulse.
    always_comb begin
        w_edit_mode   = (r_state == EDIT);
        w_commit_next = (r_state == EDIT) && r_evt_ctrl;
    end

    // Commit is registered so it lands on the same cycle the state returns to NAV.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_commit <= 1'b0;
        end else begin
            r_commit <= w_commit_next;
        end
    end

    // Selection moves only while navigating, wrapping at both ends of the list.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_sel_idx <= '0;
        end else if (r_state == NAV) begin
            if (r_evt_up) begin
                r_sel_idx <= (r_sel_idx == IDX_LAST) ? '0 : r_sel_idx + 1'b1;
            end else if (r_evt_down) begin
                r_sel_idx <= (r_sel_idx == '0) ? IDX_LAST : r_sel_idx - 1'b1;
            end
        end
    end

    // Item values change only while editing, saturating at 0 and VAL_MAX.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                r_val[i] <= '0;
            end
        end else if (r_state == EDIT) begin
            if (r_evt_up && (w_cur_val != VAL_TOP)) begin
                r_val[r_sel_idx] <= w_cur_val + 1'b1;
            end else if (r_evt_down && (w_cur_val != 4'd0)) begin
                r_val[r_sel_idx] <= w_cur_val - 1'b1;
            end
        end
    end

    assign w_cur_val = r_val[r_sel_idx];

    assign sel_idx   = r_sel_idx;
    assign edit_mode = w_edit_mode;
    assign sel_val   = w_cur_val;
    assign evt_ctrl  = r_evt_ctrl;
    assign evt_up    = r_evt_up;
    assign evt_down  = r_evt_down;
    assign commit    = r_commit;

endmodule
